strobe_result_bridge: RTL and testbench
=======================================

Name: strobe_result_bridge

Overview:
- Receive side of the divided-clock scheme. Takes words produced by logic that advances only on the divider's one-cycle strobe, and delivers them to full-rate logic over a valid/ready handshake.
- Sits between the cracking core, which is strobe-qualified, and the full-rate result/reporting path. All logic runs on fullclock.
- Buffers up to DEPTH words so that back-pressure in the fast domain does not stall the core.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DIV, 3, nominal strobe period in fullclock cycles; used only by the optional feature.

Ports:
- fullclock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- div_strobe  in  1  one-cycle pulse from the divider, high one cycle in DIV.
- in_valid  in  1  producer word valid; qualified by div_strobe.
- in_data  in  WIDTH  producer word.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer accepts the head word this cycle.
- out_data  out  WIDTH  head word, first-word-fall-through.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a strobe-qualified word was dropped.

Behaviour:
- Reset values: out_valid=0, out_data=0, level=0, overflow=0; read/write pointers=0. Reset asserted mid-operation discards all buffered words. No output glitches to stale data after reset deasserts.
- push = div_strobe && in_valid. in_valid while div_strobe=0 is ignored, so one producer word is taken at most once per strobe.
- pop = out_valid && out_ready.
- Accept rule: a push is accepted if level<DEPTH, or if level==DEPTH and pop occurs in the same cycle. Otherwise the word is dropped and overflow is set on the next edge; overflow stays set until reset.
- Write latency: an accepted push into an empty FIFO gives out_valid=1 and out_data=that word on the very next cycle (one-cycle latency, FWFT).
- Pop: the head advances on the edge. If another word is buffered, out_valid stays 1 with the next word; otherwise out_valid drops to 0.
- Simultaneous push and pop: level unchanged, ordering preserved. With level==1, the pushed word becomes the head after the edge.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. level is computed as an explicit counter (+1 on push only, -1 on pop only), never from pointer difference.
- out_data holds its value while out_valid=1 and out_ready=0. Its value is undefined-but-stable when out_valid=0; the implementation holds the last head.
- No combinational path from in_* to out_*. out_ready affects only the next-state logic.

Optional Feature:
- Macro STROBE_CHECK_EN.
- Defined:
  - adds output strobe_err (1 bit, reset 0, sticky);
  - a counter tracks cycles since the last div_strobe;
  - strobe_err is set if a strobe arrives less than DIV cycles after the previous one;
  - the first strobe after reset is never an error;
  - spacing greater than DIV is legal.
- Undefined: no counter and no port; behaviour otherwise identical.

Decomposition:
- Shared package (ntcrack_pkg): default WIDTH, DEPTH and DIV constants; localparam for the pointer width computed via clog2; the result-word layout typedef shared with the core.
- Sub-module bridge_fifo_mem: a DEPTH x WIDTH register array with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata). The control, counters and flags stay in the parent.

Test Plan:
- Reset, then strobe every 3rd cycle with in_valid=1 and data 0x11,0x22,0x33 while out_ready=1:
  - each word appears one cycle after its strobe;
  - level is never above 1;
  - overflow=0.
- out_ready=0, push 4 words (0xA0..0xA3), then push 0xA4:
  - level=4;
  - 0xA4 dropped, overflow=1 next cycle;
  - releasing out_ready drains 0xA0..0xA3 in order, then out_valid=0.
- level=4, push 0xB0 and pop in the same cycle: level stays 4; 0xB0 is the last word drained; overflow stays 0.
- in_valid=1 held for 9 cycles with strobes at cycles 2, 5 and 8: exactly 3 words accepted, level=3.
- Assert reset asynchronously (between edges) with level=2: out_valid, level and overflow go to 0 immediately; after release the FIFO accepts fresh words normally.
- With STROBE_CHECK_EN and DIV=3:
  - strobes at cycles 0, 3, 6: strobe_err=0;
  - an extra strobe at cycle 7: strobe_err=1 and remains set until reset.

Source files
------------

// File: rtl/ntcrack_pkg.sv
// Shared constants and result-word layout for the cracking core and its
// full-rate result path.
package ntcrack_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_DIV   = 3;
    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);

    // Word layout produced by the core; the bridge itself treats it as opaque bits.
    typedef struct packed {
        logic        hit;
        logic [7:0]  core_id;
        logic [22:0] cand_idx;
    } result_word_t;

endpackage

// File: rtl/strobe_result_bridge_if.sv
// Producer-side (strobe-qualified) and consumer-side (valid/ready) signals of
// the result bridge; master drives stimulus, slave is the bridge.
interface strobe_result_bridge_if #(
    parameter int WIDTH = ntcrack_pkg::DEF_WIDTH
);
    logic             div_strobe;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output div_strobe, in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  div_strobe, in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/bridge_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module bridge_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; entries are only read once level says they were written.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/strobe_result_bridge.sv
// Strobe-qualified producer to full-rate valid/ready consumer FIFO bridge (FWFT).
// Optional strobe spacing checker enabled by defining STROBE_CHECK_EN.
module strobe_result_bridge
    import ntcrack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic                   fullclock,
    input  logic                   reset,
    strobe_result_bridge_if.slave  bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`ifdef STROBE_CHECK_EN
    ,
    output logic                   strobe_err
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, accept;
    logic [WIDTH-1:0] rdata;

    // Reading at the next read pointer lets out_data be registered with no in->out path.
    bridge_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (fullclock),
        .we    (accept),
        .waddr (wptr_q),
        .wdata (bus.in_data),
        .raddr (rptr_d),
        .rdata (rdata)
    );

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        push        = bus.div_strobe && bus.in_valid;
        pop         = out_valid_q && bus.out_ready;
        accept      = push && ((level_q != LVL_W'(DEPTH)) || pop);
        rptr_d      = rptr_q + PTR_W'(pop);
        wptr_d      = wptr_q + PTR_W'(accept);
        level_d     = level_q;
        overflow_d  = overflow_q | (push & ~accept);
        out_data_d  = out_data_q;

        case ({accept, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        out_valid_d = (level_d != '0);
        // A word written into the slot that becomes head this edge is not in the array yet.
        if (out_valid_d) begin
            out_data_d = (accept && (wptr_q == rptr_d)) ? bus.in_data : rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge fullclock or posedge reset) begin
        if (reset) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign level         = level_q;
    assign overflow      = overflow_q;

`ifdef STROBE_CHECK_EN
    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] since_q, since_d;
    logic             seen_q, seen_d;
    logic             strobe_err_q, strobe_err_d;

    // since_q saturates at DIV: any longer gap is equally legal.
    always_comb begin
        since_d      = since_q;
        seen_d       = seen_q;
        strobe_err_d = strobe_err_q;
        if (bus.div_strobe) begin
            if (seen_q && (since_q < CNT_W'(DIV))) strobe_err_d = 1'b1;
            since_d = CNT_W'(1);
            seen_d  = 1'b1;
        end else if (since_q != CNT_W'(DIV)) begin
            since_d = since_q + CNT_W'(1);
        end
    end

    always_ff @(posedge fullclock or posedge reset) begin
        if (reset) begin
            since_q      <= '0;
            seen_q       <= 1'b0;
            strobe_err_q <= 1'b0;
        end else begin
            since_q      <= since_d;
            seen_q       <= seen_d;
            strobe_err_q <= strobe_err_d;
        end
    end

    assign strobe_err = strobe_err_q;
`endif
endmodule

// File: tb/tb_strobe_result_bridge.sv
// Directed, table-driven bench for strobe_result_bridge with hand-computed expectations.
module tb_strobe_result_bridge;
    import ntcrack_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int DIV   = 3;

    typedef struct {
        bit          rst_before;
        bit          s;
        bit          v;
        logic [31:0] d;
        bit          r;
        bit          ev;
        logic [31:0] ed;
        logic [2:0]  el;
        bit          eo;
    } vec_t;

    logic       fullclock = 1'b0;
    logic       reset;
    logic [2:0] level;
    logic       overflow;
`ifdef STROBE_CHECK_EN
    logic       strobe_err;
`endif
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[$];

    always #5 fullclock = ~fullclock;

    strobe_result_bridge_if #(.WIDTH(WIDTH)) bus ();

    strobe_result_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .fullclock  (fullclock),
        .reset      (reset),
        .bus        (bus),
        .level      (level),
        .overflow   (overflow)
`ifdef STROBE_CHECK_EN
        ,
        .strobe_err (strobe_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit v, input logic [31:0] d, input bit r);
        bus.div_strobe = s;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.out_ready  = r;
    endtask

    task automatic add(input bit rb, input bit s, input bit v, input logic [31:0] d, input bit r,
                       input bit ev, input logic [31:0] ed, input logic [2:0] el, input bit eo);
        vec_t t;
        t.rst_before = rb; t.s = s; t.v = v; t.d = d; t.r = r;
        t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
        vecs.push_back(t);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data"},  bus.out_data,       32'd0);
        check({tag, " level"},     32'(level),         32'd0);
        check({tag, " overflow"},  32'(overflow),      32'd0);
    endtask

    task automatic sync_reset();
        @(negedge fullclock);
        drive(0, 0, 32'd0, 0);
        reset = 1'b1;
        @(negedge fullclock);
        reset = 1'b0;
        check_reset_state("sync_reset");
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) sync_reset();
            @(negedge fullclock);
            drive(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].r);
            @(posedge fullclock);
            #1;
            check($sformatf("%s[%0d] out_valid", tag, i), 32'(bus.out_valid), 32'(vecs[i].ev));
            check($sformatf("%s[%0d] level", tag, i),     32'(level),         32'(vecs[i].el));
            check($sformatf("%s[%0d] overflow", tag, i),  32'(overflow),      32'(vecs[i].eo));
            if (vecs[i].ev)
                check($sformatf("%s[%0d] out_data", tag, i), bus.out_data, vecs[i].ed);
        end
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'd0, 0);
        #12;
        check_reset_state("por");

        // Strobe every third cycle, consumer always ready.
        add(1, 1, 1, 32'h11, 1,  1, 32'h11, 3'd1, 0);
        add(0, 0, 1, 32'h99, 1,  0, 32'h0,  3'd0, 0);
        add(0, 0, 1, 32'h99, 1,  0, 32'h0,  3'd0, 0);
        add(0, 1, 1, 32'h22, 1,  1, 32'h22, 3'd1, 0);
        add(0, 0, 1, 32'h99, 1,  0, 32'h0,  3'd0, 0);
        add(0, 0, 1, 32'h99, 1,  0, 32'h0,  3'd0, 0);
        add(0, 1, 1, 32'h33, 1,  1, 32'h33, 3'd1, 0);
        add(0, 0, 1, 32'h99, 1,  0, 32'h0,  3'd0, 0);
        // Level 1 with simultaneous push and pop: new word becomes head.
        add(0, 1, 1, 32'h44, 1,  1, 32'h44, 3'd1, 0);
        add(0, 1, 1, 32'h55, 1,  1, 32'h55, 3'd1, 0);
        add(0, 0, 0, 32'h0,  1,  0, 32'h0,  3'd0, 0);
        // Fill with consumer stalled, overflow on 0xA4, then drain in order.
        add(0, 1, 1, 32'hA0, 0,  1, 32'hA0, 3'd1, 0);
        add(0, 1, 1, 32'hA1, 0,  1, 32'hA0, 3'd2, 0);
        add(0, 1, 1, 32'hA2, 0,  1, 32'hA0, 3'd3, 0);
        add(0, 1, 1, 32'hA3, 0,  1, 32'hA0, 3'd4, 0);
        add(0, 1, 1, 32'hA4, 0,  1, 32'hA0, 3'd4, 1);
        add(0, 0, 0, 32'h0,  1,  1, 32'hA1, 3'd3, 1);
        add(0, 0, 0, 32'h0,  1,  1, 32'hA2, 3'd2, 1);
        add(0, 0, 0, 32'h0,  1,  1, 32'hA3, 3'd1, 1);
        add(0, 0, 0, 32'h0,  1,  0, 32'h0,  3'd0, 1);
        // in_valid held 9 cycles, strobes at cycles 2, 5, 8; overflow stays sticky.
        add(0, 0, 1, 32'hD0, 0,  0, 32'h0,  3'd0, 1);
        add(0, 0, 1, 32'hD1, 0,  0, 32'h0,  3'd0, 1);
        add(0, 1, 1, 32'hD2, 0,  1, 32'hD2, 3'd1, 1);
        add(0, 0, 1, 32'hD3, 0,  1, 32'hD2, 3'd1, 1);
        add(0, 0, 1, 32'hD4, 0,  1, 32'hD2, 3'd1, 1);
        add(0, 1, 1, 32'hD5, 0,  1, 32'hD2, 3'd2, 1);
        add(0, 0, 1, 32'hD6, 0,  1, 32'hD2, 3'd2, 1);
        add(0, 0, 1, 32'hD7, 0,  1, 32'hD2, 3'd2, 1);
        add(0, 1, 1, 32'hD8, 0,  1, 32'hD2, 3'd3, 1);
        add(0, 0, 0, 32'h0,  1,  1, 32'hD5, 3'd2, 1);
        run_vecs("seqA");

        // Asynchronous reset between edges with level=2 and overflow set.
        drive(0, 0, 32'd0, 0);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        #2;
        reset = 1'b0;
        @(negedge fullclock);
        drive(1, 1, 32'hE0, 0);
        @(posedge fullclock);
        #1;
        check("fresh out_valid", 32'(bus.out_valid), 32'd1);
        check("fresh out_data",  bus.out_data,       32'hE0);
        check("fresh level",     32'(level),         32'd1);
        @(negedge fullclock);
        drive(0, 0, 32'd0, 1);
        @(posedge fullclock);
        #1;
        check("fresh drained", 32'(bus.out_valid), 32'd0);
        check("fresh level0",  32'(level),         32'd0);

        // Full FIFO with push and pop in the same cycle: accepted, no overflow.
        add(1, 1, 1, 32'hC0, 0,  1, 32'hC0, 3'd1, 0);
        add(0, 1, 1, 32'hC1, 0,  1, 32'hC0, 3'd2, 0);
        add(0, 1, 1, 32'hC2, 0,  1, 32'hC0, 3'd3, 0);
        add(0, 1, 1, 32'hC3, 0,  1, 32'hC0, 3'd4, 0);
        add(0, 1, 1, 32'hB0, 1,  1, 32'hC1, 3'd4, 0);
        add(0, 0, 0, 32'h0,  1,  1, 32'hC2, 3'd3, 0);
        add(0, 0, 0, 32'h0,  1,  1, 32'hC3, 3'd2, 0);
        add(0, 0, 0, 32'h0,  1,  1, 32'hB0, 3'd1, 0);
        add(0, 0, 0, 32'h0,  1,  0, 32'h0,  3'd0, 0);
        run_vecs("seqB");

`ifdef STROBE_CHECK_EN
        // Strobes at 0, 3, 6 are legal; the extra one at 7 is too close.
        sync_reset();
        check("strobe_err reset", 32'(strobe_err), 32'd0);
        for (int c = 0; c < 11; c++) begin
            @(negedge fullclock);
            drive((c == 0 || c == 3 || c == 6 || c == 7), 0, 32'd0, 0);
            @(posedge fullclock);
            #1;
            check($sformatf("strobe_err cyc%0d", c), 32'(strobe_err), (c >= 7) ? 32'd1 : 32'd0);
        end
        sync_reset();
        check("strobe_err cleared", 32'(strobe_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
